// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared opcode, ALU function, FSM state and select encodings
//               for the multi-cycle CPU control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 3;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SLTIU = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // ALU function codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  // Register write-address select
  localparam logic [1:0] REG_R31 = 2'b00;
  localparam logic [1:0] REG_RT  = 2'b01;
  localparam logic [1:0] REG_RD  = 2'b10;

  // Next-PC select
  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_RS     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  // FSM states
  typedef enum logic [2:0] {
    ST_IF     = 3'b000,
    ST_ID     = 3'b001,
    ST_EXE_LS = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB_LD  = 3'b100,
    ST_EXE_BR = 3'b101,
    ST_EXE_AL = 3'b110,
    ST_WB_AL  = 3'b111
  } state_t;

  // True for opcodes that take the EXE_AL / WB_AL path
  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
      OP_ORI, OP_SLL, OP_SLT, OP_SLTIU: is_alu_op = 1'b1;
      default:                          is_alu_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decoder
// Description : Combinational operand decode: maps the opcode to the ALU
//               function, B-source, extension mode, shift-amount select and
//               the write-back register select.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic       sa_ext,
  output logic [1:0] wb_reg_out
);

  // Opcode to operand-path controls; unlisted opcodes leave everything 0
  always_comb begin
    alu_op     = ALU_ADD;
    alu_src_b  = 1'b0;
    ext_sel    = 1'b0;
    sa_ext     = 1'b0;
    wb_reg_out = REG_R31;
    case (op)
      OP_ADD:   begin alu_op = ALU_ADD;  wb_reg_out = REG_RD; end
      OP_SUB:   begin alu_op = ALU_SUB;  wb_reg_out = REG_RD; end
      OP_OR:    begin alu_op = ALU_OR;   wb_reg_out = REG_RD; end
      OP_AND:   begin alu_op = ALU_AND;  wb_reg_out = REG_RD; end
      OP_SLT:   begin alu_op = ALU_SLT;  wb_reg_out = REG_RD; end
      OP_SLL: begin
        alu_op     = ALU_SLL;
        alu_src_b  = 1'b1;
        sa_ext     = 1'b1;
        wb_reg_out = REG_RD;
      end
      OP_ADDI: begin
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b1;
        ext_sel    = 1'b1;
        wb_reg_out = REG_RT;
      end
      OP_SLTIU: begin
        alu_op     = ALU_SLTU;
        alu_src_b  = 1'b1;
        ext_sel    = 1'b1;
        wb_reg_out = REG_RT;
      end
      OP_ORI: begin
        alu_op     = ALU_OR;
        alu_src_b  = 1'b1;
        ext_sel    = 1'b0;
        wb_reg_out = REG_RT;
      end
      OP_LW, OP_SW: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
        ext_sel   = 1'b1;
      end
      OP_BEQ: begin
        alu_op    = ALU_SUB;
        alu_src_b = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle CPU control FSM generating every datapath
//               strobe and mux select from the IR opcode and ALU zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] decode,
  input  logic            zero,
  output logic            PCWre,
  output logic            IRWre,
  output logic            InsMemRW,
  output logic            RegWre,
  output logic [1:0]      RegOut,
  output logic            WrRegData,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            ExtSel,
  output logic            SAExt,
  output logic            ALUM2Reg,
  output logic            DataMemRw,
  output logic [1:0]      PCSrc,
  output logic [ST_W-1:0] state,
  output logic            halted
);

  state_t     st;
  logic [2:0] dec_alu_op;
  logic       dec_src_b;
  logic       dec_ext_sel;
  logic       dec_sa_ext;
  logic [1:0] dec_wb_reg_out;

  assign state = st;

  alu_op_decoder u_alu_op_decoder (
    .op         (decode),
    .alu_op     (dec_alu_op),
    .alu_src_b  (dec_src_b),
    .ext_sel    (dec_ext_sel),
    .sa_ext     (dec_sa_ext),
    .wb_reg_out (dec_wb_reg_out)
  );

  // State sequencing and halt latch; halt freezes the FSM at ID until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= ST_IF;
      halted <= 1'b0;
    end else if (!halted) begin
      case (st)
        ST_IF: st <= ST_ID;
        ST_ID: begin
          if (decode == OP_HALT) begin
            halted <= 1'b1;
          end else if (decode == OP_BEQ) begin
            st <= ST_EXE_BR;
          end else if (decode == OP_LW || decode == OP_SW) begin
            st <= ST_EXE_LS;
          end else if (is_alu_op(decode)) begin
            st <= ST_EXE_AL;
          end else begin
            // j, jr, jal and unknown opcodes finish in ID
            st <= ST_IF;
          end
        end
        ST_EXE_AL: st <= ST_WB_AL;
        ST_WB_AL:  st <= ST_IF;
        ST_EXE_BR: st <= ST_IF;
        ST_EXE_LS: st <= ST_MEM;
        ST_MEM:    st <= (decode == OP_LW) ? ST_WB_LD : ST_IF;
        ST_WB_LD:  st <= ST_IF;
        default:   st <= ST_IF;
      endcase
    end
  end

  // Output decode from the current state. ID depends on the opcode that was
  // loaded into IR at the IF->ID edge, so these cannot be precomputed a cycle
  // earlier; EXE_BR additionally follows the live zero flag.
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    RegOut    = REG_R31;
    WrRegData = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    SAExt     = 1'b0;
    ALUM2Reg  = 1'b0;
    DataMemRw = 1'b0;
    PCSrc     = PC_NEXT;
    if (!halted) begin
      // Operand decode is valid from EXE through write-back
      if (st != ST_IF && st != ST_ID) begin
        ALUOp   = dec_alu_op;
        ALUSrcB = dec_src_b;
        ExtSel  = dec_ext_sel;
        SAExt   = dec_sa_ext;
      end
      case (st)
        ST_IF: begin
          IRWre    = 1'b1;
          InsMemRW = 1'b1;
        end
        ST_ID: begin
          case (decode)
            OP_J: begin
              PCSrc = PC_JUMP;
              PCWre = 1'b1;
            end
            OP_JR: begin
              PCSrc = PC_RS;
              PCWre = 1'b1;
            end
            OP_JAL: begin
              RegWre    = 1'b1;
              RegOut    = REG_R31;
              WrRegData = 1'b0;
              PCSrc     = PC_JUMP;
              PCWre     = 1'b1;
            end
            OP_BEQ, OP_LW, OP_SW, OP_HALT: ;
            default: begin
              // Unknown opcodes execute as a nop
              if (!is_alu_op(decode)) begin
                PCSrc = PC_NEXT;
                PCWre = 1'b1;
              end
            end
          endcase
        end
        ST_EXE_AL: ALUM2Reg = 1'b0;
        ST_WB_AL: begin
          RegWre    = 1'b1;
          WrRegData = 1'b1;
          RegOut    = dec_wb_reg_out;
          PCSrc     = PC_NEXT;
          PCWre     = 1'b1;
        end
        ST_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = zero ? PC_BRANCH : PC_NEXT;
        end
        ST_EXE_LS: ALUOp = ALU_ADD;
        ST_MEM: begin
          if (decode == OP_SW) begin
            DataMemRw = 1'b1;
            PCWre     = 1'b1;
            PCSrc     = PC_NEXT;
          end else begin
            ALUM2Reg = 1'b1;
          end
        end
        ST_WB_LD: begin
          RegWre    = 1'b1;
          RegOut    = REG_RT;
          WrRegData = 1'b1;
          PCWre     = 1'b1;
          PCSrc     = PC_NEXT;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM that produces every control strobe consumed by the CPU datapath.
- Inputs: the IR opcode (decode) and the ALU zero flag. Outputs: the write enables and mux selects RegWre, PCWre, IRWre, ALUSrcB, ALUOp, ALUM2Reg, RegOut, DataMemRw, PCSrc, ExtSel, InsMemRW, WrRegData and SAExt.
- Sits beside the datapath in the CPU top; together they form the complete processor.

Parameters:
- OP_W, 6, opcode width; must match datapath decode.
- ST_W, 3, state register width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state to IF.
- decode  in  6  opcode IR[31:26] from datapath.
- zero  in  1  ALU zero flag (combinational, from A/B registers).
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read (1 = read).
- RegWre  out  1  register file write enable.
- RegOut  out  2  write-address select: 00 = r31, 01 = rt, 10 = rd.
- WrRegData  out  1  write-data select: 0 = PC+4, 1 = MDR.
- ALUSrcB  out  1  ALU B source: 0 = B register, 1 = extended immediate or sa.
- ALUOp  out  3  ALU function code.
- ExtSel  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend.
- SAExt  out  1  1 = shift amount replaces the immediate.
- ALUM2Reg  out  1  MDR source: 0 = ALU, 1 = data memory.
- DataMemRw  out  1  1 = data memory write.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target.
- state  out  3  current state, for debug/trace.
- halted  out  1  high while in HALT.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111.
  - sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- ALUOp codes: ADD 000, SUB 001, SLL 010, OR 011, AND 100, SLTU 101, SLT 110.
- State encoding: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111. HALT uses a separate 1-bit flag, so state holds at ID while halted=1.
- Default outputs: every output not listed for a state is 0. This includes PCWre, RegWre, IRWre and DataMemRw.
- IF:
  - IRWre = 1, InsMemRW = 1.
  - Next state ID. decode is not consulted in IF because it still holds the previous instruction.
- ID, decoded from decode:
  - j: PCSrc = 11, PCWre = 1; next IF.
  - jr: PCSrc = 10, PCWre = 1; next IF.
  - jal: RegWre = 1, RegOut = 00, WrRegData = 0, PCSrc = 11, PCWre = 1; next IF.
  - beq: next EXE_BR.
  - lw/sw: next EXE_LS.
  - ALU opcodes: next EXE_AL.
  - halt: set halted; all enables stay 0 from then on until reset.
  - Any unlisted opcode: executes as a nop (PCSrc = 00, PCWre = 1); next IF.
- Operand decode (EXE_AL, EXE_LS, EXE_BR) is combinational from decode and held constant through the following MEM/WB states.
  - R-type: ALUSrcB = 0.
  - addi/sltiu/lw/sw: ExtSel = 1, ALUSrcB = 1.
  - ori: ExtSel = 0, ALUSrcB = 1.
  - sll: SAExt = 1, ALUSrcB = 1, ALUOp = SLL.
  - beq: ALUOp = SUB, ALUSrcB = 0.
- EXE_AL: ALUM2Reg = 0 so the MDR captures the ALU result; next WB_AL.
- WB_AL:
  - RegWre = 1, WrRegData = 1.
  - RegOut = 10 for R-type, 01 for immediate forms.
  - PCSrc = 00, PCWre = 1; next IF.
- EXE_BR:
  - PCWre = 1, PCSrc = zero ? 01 : 00. This is the only Mealy output.
  - Next IF.
- EXE_LS: ALUOp = ADD; next MEM.
- MEM:
  - sw: DataMemRw = 1, PCWre = 1, PCSrc = 00; next IF.
  - lw: ALUM2Reg = 1; next WB_LD.
- WB_LD: RegWre = 1, RegOut = 01, WrRegData = 1, PCWre = 1, PCSrc = 00; next IF.
- CPI: j/jr/jal 2, beq 3, ALU ops 4, sw 4, lw 5.
- Reset:
  - Asserting reset, including mid-instruction, immediately forces state = IF and halted = 0, with all outputs at their IF values.
  - The first IR load occurs on the first rising edge after reset deasserts.
- Write strobes: RegWre, PCWre and DataMemRw are never asserted in the same cycle as IRWre, and each asserts for at most one cycle per instruction.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams, ALUOp codes and state encodings;
  - RegOut/PCSrc select codes.
- Natural sub-module: alu_op_decoder, combinational, mapping decode to {ALUOp, ALUSrcB, ExtSel, SAExt, RegOut for write-back}.
- The FSM core stays in control_unit.

Test Plan:
- Reset mid-MEM of lw: assert reset -> state = 000 within the same cycle, RegWre = 0, DataMemRw = 0, IRWre = 1.
- decode = 000000 (add) -> states 000, 001, 110, 111; in WB_AL RegWre = 1, RegOut = 10, WrRegData = 1, PCWre = 1; 4 cycles total.
- decode = 110001 (lw) -> 5-cycle path, ALUM2Reg = 1 in MEM, RegOut = 01 in WB_LD. decode = 110000 (sw) -> DataMemRw = 1 for exactly one cycle in MEM, then IF.
- decode = 110100 (beq): zero = 1 in EXE_BR -> PCSrc = 01, PCWre = 1; zero = 0 -> PCSrc = 00.
- decode = 111010 (jal) -> in ID RegWre = 1, RegOut = 00, WrRegData = 0, PCSrc = 11, PCWre = 1; decode = 111001 (jr) -> PCSrc = 10; 2-cycle instructions.
- decode = 111111 (halt) -> halted = 1, PCWre stays 0 for 20 cycles, reset clears halted. Unknown opcode 101010 -> nop with PCWre = 1 in ID.
